// File: rtl/ps2_kbd_pkg.sv
// Shared scan-code constants, parser state encoding and key-event layout
// for the PS/2 keyboard controller.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ERR    = 8'hFC;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;

    // Bytes that follow E1 in the Pause make sequence before it is complete.
    localparam int PAUSE_TAIL_BYTES = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_E0,
        S_F0,
        S_E0F0,
        S_PAUSE
    } parser_state_t;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

    // Keyboard self-test failure / buffer overrun codes seen at top level.
    function automatic logic is_error_code(input logic [7:0] b);
        return (b == SC_ERR) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    // Responses to host commands that carry no key information.
    function automatic logic is_cmd_response(input logic [7:0] b);
        return (b == SC_ACK) || (b == SC_RESEND) || (b == SC_ECHO);
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small show-ahead FIFO holding decoded key events until the consumer
// takes them. Pointers carry one extra wrap bit so full and empty differ.
import ps2_kbd_pkg::*;

module ps2_event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [9:0]               push_data,
    input  logic                     pop,
    output logic [9:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [9:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Head is forced to zero while empty so stale storage never shows.
    assign head = empty ? 10'd0 : mem[rd_ptr[AW-1:0]];

    // Entry storage; no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Read and write pointer advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// Turns the PS/2 receiver byte stream into set-2 key events: tracks the
// E0/F0/E1 prefixes, abandons stalled sequences, queues events for the consumer.
import ps2_kbd_pkg::*;

module ps2_keyboard_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] rx_data,
    input  logic       rx_data_en,
    output logic       rx_wait,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_release,
    output logic       overflow,
    output logic       bat_pass,
    output logic       kbd_error,
    output logic       prefix_timeout
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    PAUSE_LAST = 3'(PAUSE_TAIL_BYTES - 1);
    localparam logic [CW:0]   DEPTH_VAL  = (CW + 1)'(FIFO_DEPTH);

    parser_state_t state;
    parser_state_t state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [TW-1:0] timer_inc;
    logic [2:0]    pause_cnt;
    logic [2:0]    pause_next;
    logic          push;
    key_event_t    push_evt;
    logic          bat_next;
    logic          err_next;
    logic          tmo_next;

    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW:0]   fifo_count;
    key_event_t    head_evt;

    assign timer_inc = timer + TW'(1);
    assign pop       = evt_valid && evt_ready;
    assign evt_valid = !fifo_empty;

    assign evt_ext     = head_evt.ext;
    assign evt_release = head_evt.rel;
    assign evt_code    = head_evt.code;

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .head      (head_evt),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Parser state, prefix timer and pause byte counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            pause_cnt <= '0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            pause_cnt <= pause_next;
        end
    end

    // Next-state decode: one byte moves the parser, silence inside a prefix ages it.
    always_comb begin
        state_next = state;
        timer_next = timer;
        pause_next = pause_cnt;
        push       = 1'b0;
        push_evt   = '0;
        bat_next   = 1'b0;
        err_next   = 1'b0;
        tmo_next   = 1'b0;

        if (!enable) begin
            state_next = S_IDLE;
            timer_next = '0;
            pause_next = '0;
        end else if (rx_data_en) begin
            timer_next = '0;
            case (state)
                S_IDLE: begin
                    if (rx_data == SC_E0) begin
                        state_next = S_E0;
                    end else if (rx_data == SC_F0) begin
                        state_next = S_F0;
                    end else if (rx_data == SC_E1) begin
                        state_next = S_PAUSE;
                        pause_next = '0;
                    end else if (rx_data == SC_BAT) begin
                        bat_next = 1'b1;
                    end else if (is_error_code(rx_data)) begin
                        err_next = 1'b1;
                    end else if (!is_cmd_response(rx_data)) begin
                        push     = 1'b1;
                        push_evt = '{ext: 1'b0, rel: 1'b0, code: rx_data};
                    end
                end
                S_E0: begin
                    if (rx_data == SC_F0) begin
                        state_next = S_E0F0;
                    end else if (rx_data != SC_E0) begin
                        push       = 1'b1;
                        push_evt   = '{ext: 1'b1, rel: 1'b0, code: rx_data};
                        state_next = S_IDLE;
                    end
                end
                S_F0: begin
                    push       = 1'b1;
                    push_evt   = '{ext: 1'b0, rel: 1'b1, code: rx_data};
                    state_next = S_IDLE;
                end
                S_E0F0: begin
                    push       = 1'b1;
                    push_evt   = '{ext: 1'b1, rel: 1'b1, code: rx_data};
                    state_next = S_IDLE;
                end
                S_PAUSE: begin
                    if (pause_cnt == PAUSE_LAST) begin
                        push       = 1'b1;
                        push_evt   = '{ext: 1'b0, rel: 1'b0, code: SC_E1};
                        state_next = S_IDLE;
                        pause_next = '0;
                    end else begin
                        pause_next = pause_cnt + 3'd1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end else if (state != S_IDLE) begin
            if (timer_inc == TIMER_LAST) begin
                tmo_next   = 1'b1;
                state_next = S_IDLE;
                timer_next = '0;
                pause_next = '0;
            end else begin
                timer_next = timer_inc;
            end
        end
    end

    // Registered status: one-cycle pulses, sticky overflow and receiver arming.
    always_ff @(posedge clk) begin
        if (reset) begin
            bat_pass       <= 1'b0;
            kbd_error      <= 1'b0;
            prefix_timeout <= 1'b0;
            overflow       <= 1'b0;
            rx_wait        <= 1'b0;
        end else begin
            bat_pass       <= bat_next;
            kbd_error      <= err_next;
            prefix_timeout <= tmo_next;
            rx_wait        <= enable && (fifo_count < DEPTH_VAL);
            if (!enable) begin
                overflow <= 1'b0;
            end else if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_ctrl.sv
// Scoreboard bench for ps2_keyboard_ctrl: a set-2 reference model predicts
// events and pulses; a monitor thread compares every event the DUT presents.
module tb_ps2_keyboard_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] rx_data;
    logic       rx_data_en;
    logic       evt_ready;
    logic       rx_wait;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic       overflow;
    logic       bat_pass;
    logic       kbd_error;
    logic       prefix_timeout;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q [$];
    int         occ;
    bit         exp_ovf;

    bit         m_ext;
    bit         m_rel;
    int         m_pause_left;
    bit         exp_push;
    bit         exp_bat;
    bit         exp_err;
    logic [9:0] exp_evt;

    ps2_keyboard_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .rx_data        (rx_data),
        .rx_data_en     (rx_data_en),
        .rx_wait        (rx_wait),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_code       (evt_code),
        .evt_ext        (evt_ext),
        .evt_release    (evt_release),
        .overflow       (overflow),
        .bat_pass       (bat_pass),
        .kbd_error      (kbd_error),
        .prefix_timeout (prefix_timeout)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hang guard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model of set-2 decoding: pending prefix flags plus a count of Pause bytes still owed.
    function automatic void model_byte(input logic [7:0] b);
        exp_push = 1'b0;
        exp_bat  = 1'b0;
        exp_err  = 1'b0;
        exp_evt  = '0;
        if (m_pause_left > 0) begin
            m_pause_left--;
            if (m_pause_left == 0) begin
                exp_push = 1'b1;
                exp_evt  = {2'b00, 8'hE1};
            end
        end else if (m_rel) begin
            exp_push = 1'b1;
            exp_evt  = {m_ext, 1'b1, b};
            m_ext    = 1'b0;
            m_rel    = 1'b0;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (m_ext) begin
            exp_push = 1'b1;
            exp_evt  = {2'b10, b};
            m_ext    = 1'b0;
        end else begin
            case (b)
                8'hE1:               m_pause_left = 7;
                8'hAA:               exp_bat = 1'b1;
                8'hFC, 8'h00, 8'hFF: exp_err = 1'b1;
                8'hFA, 8'hFE, 8'hEE: ;
                default: begin
                    exp_push = 1'b1;
                    exp_evt  = {2'b00, b};
                end
            endcase
        end
    endfunction

    function automatic void model_clear();
        m_ext        = 1'b0;
        m_rel        = 1'b0;
        m_pause_left = 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One strobed byte; pulses and overflow are checked in the following cycle.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data    = b;
        rx_data_en = 1'b1;
        model_byte(b);
        if (exp_push) begin
            if (evt_ready) begin
                exp_q.push_back(exp_evt);
            end else if (occ < DEPTH) begin
                occ++;
                exp_q.push_back(exp_evt);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        tick(1);
        rx_data_en = 1'b0;
        checkOutput("bat_pass", 32'(bat_pass), 32'(exp_bat));
        checkOutput("kbd_error", 32'(kbd_error), 32'(exp_err));
        checkOutput("prefix_timeout", 32'(prefix_timeout), 32'd0);
        checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
        if (evt_ready) begin
            checkOutput("evt_valid_latency", 32'(evt_valid), 32'(exp_push));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        checkOutput("reset_rx_wait", 32'(rx_wait), 32'd0);
        checkOutput("reset_evt_valid", 32'(evt_valid), 32'd0);
        checkOutput("reset_evt_code", 32'(evt_code), 32'd0);
        checkOutput("reset_evt_flags", 32'({evt_ext, evt_release}), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_pulses", 32'({bat_pass, kbd_error, prefix_timeout}), 32'd0);
        reset = 1'b0;
        model_clear();
        occ     = 0;
        exp_ovf = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] pool [10];
        reset      = 1'b1;
        enable     = 1'b1;
        rx_data    = 8'h00;
        rx_data_en = 1'b0;
        evt_ready  = 1'b1;
        pool = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFC, 8'h00, 8'hFF, 8'hFA, 8'hFE, 8'hEE};
        fork
            begin
                tick(1);
                do_reset();
                tick(2);
                checkOutput("rx_wait_armed", 32'(rx_wait), 32'd1);

                // Make and break of a plain key, then extended make/break.
                applyStimulus(8'h1C);
                applyStimulus(8'hF0);
                applyStimulus(8'h1C);
                applyStimulus(8'hE0);
                applyStimulus(8'h75);
                applyStimulus(8'hE0);
                applyStimulus(8'hF0);
                applyStimulus(8'h75);

                // Pause sequence collapses to one event, parser returns to idle.
                applyStimulus(8'hE1);
                applyStimulus(8'h14);
                applyStimulus(8'h77);
                applyStimulus(8'hE1);
                applyStimulus(8'hF0);
                applyStimulus(8'h14);
                applyStimulus(8'hF0);
                applyStimulus(8'h77);
                applyStimulus(8'h1C);

                // Status codes.
                applyStimulus(8'hAA);
                applyStimulus(8'hFC);
                applyStimulus(8'h00);
                applyStimulus(8'hFF);
                applyStimulus(8'hFA);
                tick(2);

                // Abandoned F0 prefix: pulse exactly TMO cycles after the strobe cycle.
                applyStimulus(8'hF0);
                for (int k = 1; k <= TMO + 3; k++) begin
                    checkOutput("timeout_pulse", 32'(prefix_timeout), 32'(k == TMO));
                    tick(1);
                end
                model_clear();
                applyStimulus(8'h1C);

                // Reset in the middle of an extended sequence.
                applyStimulus(8'hE0);
                do_reset();
                tick(2);
                applyStimulus(8'h1C);
                tick(2);

                // Fill the FIFO with the consumer stalled.
                evt_ready = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    applyStimulus(8'(8'h10 + i));
                end
                tick(2);
                checkOutput("rx_wait_full", 32'(rx_wait), 32'd0);
                checkOutput("evt_valid_full", 32'(evt_valid), 32'd1);
                applyStimulus(8'h2A);
                checkOutput("queued_after_drop", 32'(exp_q.size()), 32'(DEPTH));
                evt_ready = 1'b1;
                tick(1);
                evt_ready = 1'b0;
                occ--;
                tick(2);
                checkOutput("rx_wait_rearmed", 32'(rx_wait), 32'd1);
                checkOutput("overflow_sticky", 32'(overflow), 32'd1);

                // Disable: overflow clears, receiver disarms, stored events survive, bytes ignored.
                enable     = 1'b0;
                rx_data    = 8'h1C;
                rx_data_en = 1'b1;
                tick(1);
                rx_data_en = 1'b0;
                exp_ovf    = 1'b0;
                checkOutput("overflow_cleared", 32'(overflow), 32'd0);
                tick(1);
                checkOutput("rx_wait_disabled", 32'(rx_wait), 32'd0);
                checkOutput("fifo_retained", 32'(evt_valid), 32'd1);
                enable    = 1'b1;
                evt_ready = 1'b1;
                for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
                    tick(1);
                end
                checkOutput("drained", 32'(exp_q.size()), 32'd0);
                occ = 0;
                tick(2);
                checkOutput("fifo_empty_after_drain", 32'(evt_valid), 32'd0);

                // Randomized byte stream against the model.
                for (int n = 0; n < 300; n++) begin
                    int r;
                    r = $urandom_range(0, 19);
                    if (r < 10) begin
                        applyStimulus(pool[r]);
                    end else begin
                        applyStimulus(8'($urandom_range(0, 255)));
                    end
                    tick($urandom_range(0, 2));
                end
                tick(5);
                checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
            end
            begin
                // Monitor: every accepted head event must match the next expected one.
                forever begin
                    @(negedge clk);
                    if (!reset && evt_valid && evt_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("[TB] FAIL unexpected_event actual=0x%0h required=none",
                                     {evt_ext, evt_release, evt_code});
                        end else begin
                            checkOutput("event", 32'({evt_ext, evt_release, evt_code}),
                                        32'(exp_q.pop_front()));
                        end
                    end
                end
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
